// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase scheduler:
//   - phase_e      : the three lamp phases an intersection cycles through
//   - DEF_*        : default approach count and timing lengths, in ticks
//   - bitsFor      : width needed to hold the values 0 .. v-1 (at least 1 bit)
//   - maxOf3       : largest of three timing lengths, used to size the timer
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } phase_e;

    localparam int DEF_N_APPR      = 4;
    localparam int DEF_T_MIN_GREEN = 8;
    localparam int DEF_T_MAX_GREEN = 15;
    localparam int DEF_T_YELLOW    = 3;
    localparam int DEF_T_ALLRED    = 1;

    function automatic int bitsFor(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_phase_sched_if.sv
// ----------------------------------------------------------------------------
// traffic_phase_sched_if
// Bundles the scheduler's timebase, sensor and lamp signals.
//   tick        : timebase enable, timers only advance when high
//   req         : level vehicle-sensor request, one bit per approach
//   red/yellow/green : per-approach lamp drive, exactly one high per approach
//   active_idx  : approach that currently owns the intersection
//   phase_done  : one-cycle pulse on the first cycle of every new green
// Modports:
//   master : the environment (drives tick/req, observes lamps)
//   slave  : the scheduler itself
// ----------------------------------------------------------------------------
interface traffic_phase_sched_if
    import traffic_pkg::*;
#(
    parameter int N_APPR = DEF_N_APPR
);

    localparam int IDX_W = bitsFor(N_APPR);

    logic              tick;
    logic [N_APPR-1:0] req;
    logic [N_APPR-1:0] red;
    logic [N_APPR-1:0] yellow;
    logic [N_APPR-1:0] green;
    logic [IDX_W-1:0]  active_idx;
    logic              phase_done;

    modport master (
        output tick, req,
        input  red, yellow, green, active_idx, phase_done
    );

    modport slave (
        input  tick, req,
        output red, yellow, green, active_idx, phase_done
    );

endinterface

// File: rtl/traffic_phase_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selection of the next approach to get green.
//   pend_i       : latched requests per approach
//   active_idx_i : approach currently owning the intersection
//   valid_o      : a candidate exists
//   idx_o        : the candidate approach
// Scans from active_idx_i+1 upward with wrap-around; if nothing is pending,
// the main road (approach 0) is offered unless it already owns the junction.
// ----------------------------------------------------------------------------
module rr_pick
    import traffic_pkg::*;
#(
    parameter int N_APPR = DEF_N_APPR
) (
    input  logic [N_APPR-1:0]          pend_i,
    input  logic [bitsFor(N_APPR)-1:0] active_idx_i,
    output logic                       valid_o,
    output logic [bitsFor(N_APPR)-1:0] idx_o
);

    localparam int IDX_W = bitsFor(N_APPR);

    logic [IDX_W-1:0] j;

    // Walk the ring from the farthest offset back to the nearest one, so the
    // nearest pending approach after the current owner is the last to write
    // and therefore wins. The main road fallback only applies when nothing
    // is pending at all.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = N_APPR; k >= 1; k--) begin
            j = IDX_W'((int'(active_idx_i) + k) % N_APPR);
            if (pend_i[j]) begin
                valid_o = 1'b1;
                idx_o   = j;
            end
        end
        if (!valid_o && (active_idx_i != '0)) begin
            valid_o = 1'b1;
            idx_o   = '0;
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// ----------------------------------------------------------------------------
// traffic_phase_sched
// Round-robin traffic light phase scheduler for N_APPR approaches sharing an
// intersection. Approach 0 is the main road and rests green when nobody else
// is waiting. Each served approach passes through GREEN -> YELLOW -> ALLRED
// before the next owner gets green.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; returns to main-road green, drops
//           all latched requests
//   bus   : traffic_phase_sched_if.slave (tick, req, lamps, active_idx,
//           phase_done)
// ----------------------------------------------------------------------------
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int N_APPR      = DEF_N_APPR,
    parameter int T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int T_YELLOW    = DEF_T_YELLOW,
    parameter int T_ALLRED    = DEF_T_ALLRED
) (
    input  logic                        clk,
    input  logic                        reset,
    traffic_phase_sched_if.slave        bus
);

    localparam int IDX_W   = bitsFor(N_APPR);
    // The timer must reach the last tick of whichever interval is longest;
    // with the default timings this is T_MAX_GREEN-1.
    localparam int CNT_TOP = maxOf3(T_MAX_GREEN, T_YELLOW, T_ALLRED);
    localparam int CNT_W   = bitsFor(CNT_TOP);

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_TOP - 1);
    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(T_ALLRED - 1);

    phase_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  activeIdx_q, activeIdx_d;
    logic [IDX_W-1:0]  nextIdx_q, nextIdx_d;
    logic [N_APPR-1:0] pend_q, pend_d;
    logic              phaseDone_q, phaseDone_d;

    logic              pickValid;
    logic [IDX_W-1:0]  pickIdx;
    logic [N_APPR-1:0] greenMask;
    logic [N_APPR-1:0] lampRed, lampYellow, lampGreen;

    rr_pick #(
        .N_APPR (N_APPR)
    ) u_pick (
        .pend_i       (pend_q),
        .active_idx_i (activeIdx_q),
        .valid_o      (pickValid),
        .idx_o        (pickIdx)
    );

    // The owner's own sensor is ignored while it is green; it only needs to
    // be remembered once its green has ended.
    assign greenMask = (state_q == ST_GREEN) ? (N_APPR'(1) << activeIdx_q) : '0;

    // State register: every piece of scheduler state moves together on the
    // clock edge; reset puts the main road back in green with a clean slate.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_GREEN;
            cnt_q       <= '0;
            activeIdx_q <= '0;
            nextIdx_q   <= '0;
            pend_q      <= '0;
            phaseDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            activeIdx_q <= activeIdx_d;
            nextIdx_q   <= nextIdx_d;
            pend_q      <= pend_d;
            phaseDone_q <= phaseDone_d;
        end
    end

    // Next-state logic. Requests latch every cycle regardless of tick; the
    // timer and phase only move on tick cycles. Green ends once minimum green
    // has elapsed and someone else is waiting, but a still-present owner keeps
    // it up to the maximum green. The chosen successor is frozen in nextIdx
    // at the start of yellow so late requests cannot reorder the hand-over.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        activeIdx_d = activeIdx_q;
        nextIdx_d   = nextIdx_q;
        phaseDone_d = 1'b0;
        pend_d      = pend_q | (bus.req & ~greenMask);

        if (bus.tick) begin
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_GREEN: begin
                    if (pickValid && (cnt_q >= MIN_LAST) &&
                        (!bus.req[activeIdx_q] || (cnt_q >= MAX_LAST))) begin
                        state_d   = ST_YELLOW;
                        cnt_d     = '0;
                        nextIdx_d = pickIdx;
                    end
                end
                ST_YELLOW: begin
                    if (cnt_q == YEL_LAST) begin
                        state_d = ST_ALLRED;
                        cnt_d   = '0;
                    end
                end
                ST_ALLRED: begin
                    if (cnt_q == AR_LAST) begin
                        state_d             = ST_GREEN;
                        cnt_d               = '0;
                        activeIdx_d         = nextIdx_q;
                        phaseDone_d         = 1'b1;
                        pend_d[nextIdx_q]   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_GREEN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Lamp decode straight from registered phase and owner: everyone is red
    // except the owner during green or yellow.
    always_comb begin
        lampRed    = '1;
        lampYellow = '0;
        lampGreen  = '0;
        case (state_q)
            ST_GREEN: begin
                lampRed[activeIdx_q]   = 1'b0;
                lampGreen[activeIdx_q] = 1'b1;
            end
            ST_YELLOW: begin
                lampRed[activeIdx_q]    = 1'b0;
                lampYellow[activeIdx_q] = 1'b1;
            end
            default: begin
                lampRed = '1;
            end
        endcase
    end

    assign bus.red        = lampRed;
    assign bus.yellow     = lampYellow;
    assign bus.green      = lampGreen;
    assign bus.active_idx = activeIdx_q;
    assign bus.phase_done = phaseDone_q;

endmodule

// File: doc/traffic_phase_sched.md
TRAFFIC_PHASE_SCHED -- requirements
Module: traffic_phase_sched

Interface
REQ-001 Parameter N_APPR, default 4, number of approaches sharing the intersection (index 0 = main road, rest approach).
REQ-002 Parameter T_MIN_GREEN, default 8, minimum green length in ticks.
REQ-003 Parameter T_MAX_GREEN, default 15, maximum green length in ticks while others wait.
REQ-004 Parameter T_YELLOW, default 3, yellow length in ticks.
REQ-005 Parameter T_ALLRED, default 1, all-red clearance length in ticks.
REQ-006 clk  input  1  single clock; all state changes on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 tick  input  1  timebase enable; all timers advance only on cycles with tick=1.
REQ-009 req  input  N_APPR  level vehicle-sensor request per approach.
REQ-010 red, yellow, green  output  N_APPR each  per-approach lamp drive, one-hot per approach.
REQ-011 active_idx  output  $clog2(N_APPR)  approach currently owning the intersection.
REQ-012 phase_done  output  1  one-cycle pulse when a new green phase starts.

Function
REQ-013 FSM states: GREEN, YELLOW, ALLRED; only active_idx lit green/yellow, all others red; ALLRED lights red on all approaches.
REQ-014 Lamp outputs shall be Moore decodes of registered state and active_idx only, with exactly one of red/yellow/green high per approach every cycle.
REQ-015 pend[i] shall set on any cycle with req[i]=1, except i==active_idx while in GREEN, and shall clear when approach i enters GREEN; req during YELLOW/ALLRED is latched.
REQ-016 Tick counter cnt shall clear on every state entry, increment on tick, and saturate at T_MAX_GREEN-1.
REQ-017 Next owner: first pending approach scanning round-robin from active_idx+1; if none pending and active_idx!=0, next is 0; otherwise no candidate.
REQ-018 GREEN→YELLOW on a tick when a candidate exists, cnt>=T_MIN_GREEN-1, and (req[active_idx]==0 or cnt==T_MAX_GREEN-1); the candidate is captured into next_idx on that edge.
REQ-019 With no candidate, GREEN holds indefinitely (approach 0 rests green).
REQ-020 YELLOW→ALLRED on the tick with cnt==T_YELLOW-1; ALLRED→GREEN on the tick with cnt==T_ALLRED-1, loading active_idx<=next_idx and pulsing phase_done for that one cycle.
REQ-021 tick=0 shall freeze cnt and state; pend latching continues.
REQ-022 Simultaneous requests are served one per phase in round-robin order; none starves beyond (N_APPR-1) phases.
REQ-023 Timer widths shall hold T_MAX_GREEN-1 without overflow; parameters require T_MIN_GREEN<=T_MAX_GREEN and all times >=1.

Reset
REQ-024 On reset=1 at a clock edge: state=GREEN, active_idx=0, next_idx=0, cnt=0, pend=0, phase_done=0; green[0]=1, red[others]=1, in any state.
REQ-025 Reset mid-phase takes effect on the next edge, discards pending requests, and produces no phase_done pulse.

Structure
REQ-026 Package traffic_pkg shall hold the phase state enum and the default timing constants.
REQ-027 Round-robin next-owner selection shall be a combinational sub-module rr_pick (inputs pend, active_idx; outputs valid, idx).

Verification
REQ-028 Reset, req=0, tick every cycle for 40 cycles -> green[0]=1, red[1..3]=1, phase_done never asserted.
REQ-029 req[2] pulsed one cycle at tick 2 of approach-0 green, req[0]=0 -> green[0] for 8 ticks, yellow[0] 3 ticks, all-red 1 tick, then green[2], active_idx=2, phase_done one pulse; then 8 ticks later back to 0.
REQ-030 req[0] held high, req[1] asserted at tick 0 -> approach 0 stays green exactly 15 ticks, then yellow.
REQ-031 req[1] and req[3] asserted same cycle while 0 green -> green order 1, 3, 0 with yellow/all-red between each.
REQ-032 reset asserted during YELLOW with pend[3]=1 -> next cycle green[0]=1, pend=0, approach 3 not served without a new request.
REQ-033 tick held 0 for 100 cycles mid-GREEN with pending request -> state, cnt and lamps unchanged; resumes exactly where it left off.
